// File: rtl/stereolbm_mul_pipe_pkg.sv
// stereolbm_mul_pkg: width, rounding and saturation helpers shared by the multiplier pipeline
package stereolbm_mul_pkg;

    function automatic int prod_w(int din0_w, int din1_w);
        return din0_w + din1_w + 1;
    endfunction

    function automatic logic signed [127:0] rnd_const(int shift, int rnd);
        return (rnd != 0 && shift > 0) ? 128'sd1 <<< (shift - 1) : 128'sd0;
    endfunction

    function automatic logic signed [127:0] sat_max(int w, bit sgn);
        return sgn ? (128'sd1 <<< (w - 1)) - 128'sd1 : (128'sd1 <<< w) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(int w, bit sgn);
        return sgn ? -(128'sd1 <<< (w - 1)) : 128'sd0;
    endfunction

endpackage

// File: rtl/stereolbm_mul_pipe_if.sv
// stereolbm_mul_pipe_if: valid/ready operand and result streams of the multiplier
interface stereolbm_mul_pipe_if #(
    parameter int DIN0_W = 32,
    parameter int DIN1_W = 11,
    parameter int DOUT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] dout;

    modport master (output in_valid, din0, din1, out_ready, input in_ready, out_valid, dout);
    modport slave  (input in_valid, din0, din1, out_ready, output in_ready, out_valid, dout);
endinterface

// File: rtl/stereolbm_mul_pipe_reg.sv
// stereolbm_pipe_reg: one valid+data pipeline slice with enable and async active-low reset
module stereolbm_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         vin,
    input  logic [W-1:0] din,
    output logic         vout,
    output logic [W-1:0] dout
);

    // slice advances only when the whole pipeline advances
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (en) begin
            vout <= vin;
            dout <= din;
        end
    end

endmodule

// File: rtl/stereolbm_mul_pipe.sv
// stereolbm_mul_pipe: pipelined multiplier with valid/ready flow control; define STEREOLBM_MUL_SAT_EN to clamp instead of wrap
module stereolbm_mul_pipe
    import stereolbm_mul_pkg::*;
#(
    parameter int DIN0_W    = 32,
    parameter int DIN1_W    = 11,
    parameter int DIN0_SGN  = 1,
    parameter int DIN1_SGN  = 0,
    parameter int DOUT_W    = 32,
    parameter int SHIFT     = 0,
    parameter int RND       = 0,
    parameter int NUM_STAGE = 2
) (
    input logic clk,
    input logic reset_n,
    stereolbm_mul_pipe_if.slave bus
);

    localparam int PW = prod_w(DIN0_W, DIN1_W);
    localparam int QW = PW + 1;
    localparam int OW = DIN0_W + DIN1_W;
    localparam logic signed [127:0] RC = rnd_const(SHIFT, RND);
`ifdef STEREOLBM_MUL_SAT_EN
    localparam logic signed [127:0] QMAX = sat_max(DOUT_W, (DIN0_SGN | DIN1_SGN) != 0);
    localparam logic signed [127:0] QMIN = sat_min(DOUT_W, (DIN0_SGN | DIN1_SGN) != 0);
`endif

    logic                                adv;
    logic [NUM_STAGE-1:0]                v;
    logic [NUM_STAGE-1:0][DOUT_W-1:0]    d;
    logic [OW-1:0]                       op;
    logic [DIN0_W-1:0]                   o0;
    logic [DIN1_W-1:0]                   o1;
    logic signed [PW-1:0]                a;
    logic signed [PW-1:0]                b;
    logic signed [PW-1:0]                p;
    logic signed [QW-1:0]                q;
    logic [DOUT_W-1:0]                   res;

    assign adv           = ~v[NUM_STAGE-1] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[NUM_STAGE-1];
    assign bus.dout      = d[NUM_STAGE-1];

    stereolbm_pipe_reg #(.W(OW)) u_s0 (
        .clk(clk), .reset_n(reset_n), .en(adv), .vin(bus.in_valid),
        .din({bus.din0, bus.din1}), .vout(v[0]), .dout(op)
    );

    assign {o0, o1} = op;
    assign d[0] = res;

    // extend registered operands, multiply, round, shift and fit to the output width
    always_comb begin
        a = {{(PW-DIN0_W){DIN0_SGN != 0 && o0[DIN0_W-1]}}, o0};
        b = {{(PW-DIN1_W){DIN1_SGN != 0 && o1[DIN1_W-1]}}, o1};
        p = a * b;
        q = (QW'(p) + QW'(RC)) >>> SHIFT;
`ifdef STEREOLBM_MUL_SAT_EN
        res = q > QMAX ? DOUT_W'(QMAX) : q < QMIN ? DOUT_W'(QMIN) : DOUT_W'(q);
`else
        res = DOUT_W'(q);
`endif
    end

    for (genvar i = 1; i < NUM_STAGE; i++) begin : g_stage
        stereolbm_pipe_reg #(.W(DOUT_W)) u_s (
            .clk(clk), .reset_n(reset_n), .en(adv), .vin(v[i-1]),
            .din(d[i-1]), .vout(v[i]), .dout(d[i])
        );
    end

endmodule

// File: tb/tb_stereolbm_mul_pipe.sv
// tb_stereolbm_mul_pipe: directed vectors, stall/reset sequences and random traffic on five multiplier configurations
module tb_stereolbm_mul_pipe;

    localparam int ND = 5;
    localparam int NS [ND] = '{2, 1, 5, 2, 2};
    localparam int SH [ND] = '{0, 0, 0, 4, 4};
    localparam int RN [ND] = '{0, 0, 0, 1, 0};
    localparam longint LMAX = 64'sh7FFF_FFFF;
    localparam longint LMIN = -64'sh8000_0000;
`ifdef STEREOLBM_MUL_SAT_EN
    localparam logic [31:0] OVF_E = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_E = 32'hFFFF_FFFE;
`endif

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [10:0] b;
        logic [31:0] e;
        string       nm;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [ND-1:0] iv = '0;
    logic [ND-1:0] ordy = '1;
    logic [ND-1:0] ir;
    logic [ND-1:0] ov;
    logic [31:0]   d0 [ND];
    logic [10:0]   d1 [ND];
    logic [31:0]   dq [ND];

    int total = 0;
    int bad = 0;
    logic [31:0] sa[$];
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : gd
        stereolbm_mul_pipe_if #(.DIN0_W(32), .DIN1_W(11), .DOUT_W(32)) mi ();
        assign mi.in_valid  = iv[g];
        assign mi.din0      = d0[g];
        assign mi.din1      = d1[g];
        assign mi.out_ready = ordy[g];
        assign ir[g]        = mi.in_ready;
        assign ov[g]        = mi.out_valid;
        assign dq[g]        = mi.dout;
        stereolbm_mul_pipe #(.NUM_STAGE(NS[g]), .SHIFT(SH[g]), .RND(RN[g])) dut (
            .clk(clk), .reset_n(reset_n), .bus(mi.slave)
        );
    end

    function automatic logic [31:0] model(int k, logic [31:0] a, logic [10:0] b);
        longint p;
        p = longint'($signed(a)) * longint'(b);
        if (RN[k] != 0 && SH[k] > 0) p += longint'(1) << (SH[k] - 1);
        p = p >>> SH[k];
`ifdef STEREOLBM_MUL_SAT_EN
        if (p > LMAX) p = LMAX;
        if (p < LMIN) p = LMIN;
`endif
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic vec(input vec_t t);
        int j;
        @(negedge clk);
        iv[t.k] = 1'b1; d0[t.k] = t.a; d1[t.k] = t.b; ordy[t.k] = 1'b1;
        #1 chk({t.nm, "_rdy"}, ir[t.k], 1);
        @(posedge clk);
        @(negedge clk);
        iv[t.k] = 1'b0;
        #1 j = 0;
        while (!ov[t.k] && j < NS[t.k] + 3) begin
            @(negedge clk);
            #1 j++;
        end
        chk({t.nm, "_lat"}, j, NS[t.k] - 1);
        chk({t.nm, "_dout"}, dq[t.k], t.e);
    endtask

    task automatic run(input int k, input bit burst, input string nm);
        int n = sa.size();
        int sent = 0, got = 0, cyc = 0, stalls = 0, hold = 0;
        bit started = 0, pend = 0, extra = 0;
        logic [31:0] eq[$];
        while (got < n && cyc < n * 10 + 50) begin
            @(negedge clk);
            if (sent < n) begin
                iv[k] = pend | burst | ($urandom_range(0, 4) != 0);
                d0[k] = sa[sent]; d1[k] = sb[sent];
            end else iv[k] = 1'b0;
            if (burst) begin
                if (!started && ov[k]) begin started = 1; hold = 3; end
                ordy[k] = (hold == 0);
                if (hold > 0) hold--;
            end else ordy[k] = ($urandom_range(0, 3) != 0);
            #1 chk($sformatf("%s_k%0d_inrdy%0d", nm, k, cyc), ir[k], !ov[k] || ordy[k]);
            if (!ir[k]) stalls++;
            pend = iv[k] & ~ir[k];
            if (ov[k] && ordy[k]) begin
                if (eq.size() == 0) chk($sformatf("%s_k%0d_spurious", nm, k), 1, 0);
                else chk($sformatf("%s_k%0d_out%0d", nm, k, got), dq[k], eq.pop_front());
                got++;
            end
            if (iv[k] && ir[k]) begin
                eq.push_back(model(k, sa[sent], sb[sent]));
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        iv[k] = 1'b0; ordy[k] = 1'b1;
        chk($sformatf("%s_k%0d_count", nm, k), got, n);
        if (burst) chk($sformatf("%s_k%0d_stalls", nm, k), stalls, 3);
        repeat (NS[k] + 3) begin
            @(negedge clk);
            #1 extra |= ov[k];
        end
        chk($sformatf("%s_k%0d_extra", nm, k), extra, 0);
    endtask

    initial begin
        vec_t tbl[$];
        bit stale, nrdy;
        for (int k = 0; k < ND; k++) begin d0[k] = '0; d1[k] = '0; end
        tbl.push_back('{0, 32'hFFFF_FFFD, 11'd5,     32'hFFFF_FFF1, "neg3x5"});
        tbl.push_back('{0, 32'd1,         11'h7FF,   32'd2047,      "din1_unsigned"});
        tbl.push_back('{0, 32'h7FFF_FFFF, 11'd2,     OVF_E,         "overflow"});
        tbl.push_back('{0, 32'h8000_0000, 11'h7FF,   32'h8000_0000, "min_x_max"});
        tbl.push_back('{0, 32'd0,         11'd0,     32'd0,         "zero"});
        tbl.push_back('{1, 32'hFFFF_FFFD, 11'd5,     32'hFFFF_FFF1, "ns1_neg3x5"});
        tbl.push_back('{2, 32'hFFFF_FFFD, 11'd5,     32'hFFFF_FFF1, "ns5_neg3x5"});
        tbl.push_back('{3, 32'd24,        11'd1,     32'd2,         "rnd_pos"});
        tbl.push_back('{3, 32'hFFFF_FFE8, 11'd1,     32'hFFFF_FFFF, "rnd_neg"});
        tbl.push_back('{4, 32'd24,        11'd1,     32'd1,         "trunc_pos"});
        tbl.push_back('{4, 32'hFFFF_FFE8, 11'd1,     32'hFFFF_FFFE, "trunc_neg"});

        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_ov%0d", k), ov[k], 0);
            chk($sformatf("rst_dq%0d", k), dq[k], 0);
            chk($sformatf("rst_ir%0d", k), ir[k], 1);
        end
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) vec(tbl[i]);

        for (int k = 0; k < 3; k++) begin
            sa = {32'd1, 32'd2, 32'd3, 32'd4};
            sb = {11'd3, 11'd3, 11'd3, 11'd3};
            run(k, 1'b1, "burst");
        end

        for (int k = 0; k < ND; k++) begin
            sa.delete(); sb.delete();
            for (int i = 0; i < 40; i++) begin
                sa.push_back(i % 7 == 0 ? 32'h7FFF_FFFF : i % 7 == 1 ? 32'h8000_0000 : $urandom);
                sb.push_back(11'($urandom_range(0, 2047)));
            end
            run(k, 1'b0, "rand");
        end

        @(negedge clk);
        iv[0] = 1'b1; iv[2] = 1'b1; d0[0] = 32'd7; d0[2] = 32'd7;
        d1[0] = 11'd3; d1[2] = 11'd3; ordy[0] = 1'b1; ordy[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d0[0] = 32'd8; d0[2] = 32'd8;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0; iv[2] = 1'b0;
        #1 chk("pre_rst_ov0", ov[0], 1);
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("midrst_ov%0d", k), ov[k], 0);
            chk($sformatf("midrst_dq%0d", k), dq[k], 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        stale = 0; nrdy = 0;
        repeat (8) begin
            @(negedge clk);
            #1 stale |= ov[0] | ov[2];
            nrdy |= ~ir[0] | ~ir[2];
        end
        chk("post_rst_stale", stale, 0);
        chk("post_rst_inrdy", nrdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
